// File: rtl/wb_burst_ram_slave_if.sv
// Wishbone B4 slave-port bundle for wb_burst_ram_slave.
// Signal names are seen from the slave side: *_i flows master -> slave,
// *_o flows slave -> master.
//   sa_addr_i  word address        sa_dat_i  write data
//   sa_sel_i   byte enables        sa_tag_i  tag (ignored by the RAM)
//   sa_we_i    write enable        sa_cyc_i  bus cycle
//   sa_stb_i   strobe              sa_cti_i  cycle type
//   sa_bte_i   burst type          sa_dat_o  read data
//   sa_ack_o   acknowledge         sa_err_o  error
//   sa_rty_o   retry
interface wb_burst_ram_slave_if #(
  parameter int Dw   = 32,
  parameter int Aw   = 10,
  parameter int SELw = 4,
  parameter int TAGw = 3,
  parameter int CTIw = 3,
  parameter int BTEw = 2
);
  logic [Aw-1:0]   sa_addr_i;
  logic [Dw-1:0]   sa_dat_i;
  logic [SELw-1:0] sa_sel_i;
  logic [TAGw-1:0] sa_tag_i;
  logic            sa_we_i;
  logic            sa_cyc_i;
  logic            sa_stb_i;
  logic [CTIw-1:0] sa_cti_i;
  logic [BTEw-1:0] sa_bte_i;
  logic [Dw-1:0]   sa_dat_o;
  logic            sa_ack_o;
  logic            sa_err_o;
  logic            sa_rty_o;

  modport slave (
    input  sa_addr_i, sa_dat_i, sa_sel_i, sa_tag_i, sa_we_i,
           sa_cyc_i, sa_stb_i, sa_cti_i, sa_bte_i,
    output sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
  );

  modport master (
    output sa_addr_i, sa_dat_i, sa_sel_i, sa_tag_i, sa_we_i,
           sa_cyc_i, sa_stb_i, sa_cti_i, sa_bte_i,
    input  sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
  );
endinterface

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B4 registered-feedback RAM slave.
// Classic cycles are answered one clock after the request; incrementing
// bursts (CTI=010) stream one beat per clock after that first clock, with
// linear / wrap4 / wrap8 / wrap16 address sequencing. Addresses at or above
// MEM_WORDS are answered with a one-cycle err pulse instead of ack.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    slave modport of wb_burst_ram_slave_if (adr/dat/sel/tag/we/cyc/
//          stb/cti/bte in, dat/ack/err/rty out)
module wb_burst_ram_slave #(
  parameter int Dw        = 32,
  parameter int Aw        = 10,
  parameter int SELw      = 4,
  parameter int TAGw      = 3,
  parameter int CTIw      = 3,
  parameter int BTEw      = 2,
  parameter int MEM_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_burst_ram_slave_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST} state_t;

  localparam int              IW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [Aw:0]     MEM_LIM  = (Aw+1)'(MEM_WORDS);
  localparam logic [CTIw-1:0] CTI_INCR = CTIw'(3'b010);

  logic [Dw-1:0] mem [0:MEM_WORDS-1];

  state_t        state_q, state_d;
  logic [Aw-1:0] adr_q, adr_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [Dw-1:0] dat_q, dat_d;
  logic [Aw-1:0] nxt_adr;
  logic          wr_en;

  // Wrap bursts advance only the low bits selected by the mask; a mask wider
  // than Aw truncates, which makes the wrap happen at Aw instead.
  function automatic logic [Aw-1:0] next_adr(input logic [Aw-1:0] a,
                                             input logic [BTEw-1:0] bte);
    logic [Aw-1:0] m;
    if (bte == BTEw'(1))      m = Aw'(4'd3);
    else if (bte == BTEw'(2)) m = Aw'(4'd7);
    else if (bte == BTEw'(3)) m = Aw'(4'd15);
    else                      m = '1;
    return (a & ~m) | ((a + Aw'(1)) & m);
  endfunction

  function automatic logic in_range(input logic [Aw-1:0] a);
    return {1'b0, a} < MEM_LIM;
  endfunction

  // Only ever used for in-range addresses, where the low IW bits are the
  // whole address.
  function automatic logic [IW-1:0] idx(input logic [Aw-1:0] a);
    return a[IW-1:0];
  endfunction

  // The beat currently acknowledged is completed by the edge that sees stb.
  // ack is only ever raised for in-range addresses, so no range check here.
  assign wr_en   = ack_q & bus.sa_cyc_i & bus.sa_stb_i & bus.sa_we_i;
  assign nxt_adr = next_adr(adr_q, bus.sa_bte_i);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    if (!bus.sa_cyc_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // err_q blocks re-acceptance of the strobe that was just errored.
          if (bus.sa_stb_i && !err_q) begin
            adr_d = bus.sa_addr_i;
            if (in_range(bus.sa_addr_i)) begin
              ack_d   = 1'b1;
              dat_d   = mem[idx(bus.sa_addr_i)];
              state_d = (bus.sa_cti_i == CTI_INCR) ? S_BURST : S_CLASSIC;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_CLASSIC: begin
          state_d = S_IDLE;
        end
        S_BURST: begin
          // ack is high throughout BURST, so stb alone accepts the beat and
          // the following word is fetched on the same edge.
          if (bus.sa_stb_i && bus.sa_cti_i == CTI_INCR) begin
            adr_d = nxt_adr;
            if (in_range(nxt_adr)) begin
              ack_d = 1'b1;
              dat_d = mem[idx(nxt_adr)];
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // The write lands on the edge that completes the beat, so any read issued
  // afterwards (earliest: the next edge) already sees the new data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < SELw; i++) begin
        if (bus.sa_sel_i[i]) mem[idx(adr_q)][8*i +: 8] <= bus.sa_dat_i[8*i +: 8];
      end
    end
  end

  assign bus.sa_dat_o = dat_q;
  assign bus.sa_ack_o = ack_q;
  assign bus.sa_err_o = err_q;
  assign bus.sa_rty_o = 1'b0;

endmodule
